dpram_lsu_bridge: RTL and testbench



---
 rtl/dpram_lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/dpram_lsu_bridge.sv | 186 ++++++++++++++++++
 tb/tb_dpram_lsu_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dpram_lsu_pkg.sv
// Shared encodings for the dual-port SRAM load/store bridge.
package dpram_lsu_pkg;

    // Access size encodings on req_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Bridge FSM states
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SPLIT = 1'b1;

    // Unshifted byte-lane mask for an access size
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store mask/rotate and load shift/extend (combinational).
module lsu_lane_align
    import dpram_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [7:0]  st_mask,
    output logic [31:0] st_din,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);
    logic [31:0] st_rep;
    logic [63:0] st_rot;
    logic [63:0] ld_sh;
    logic        unused_bits;

    assign unused_bits = ^{st_rot[31:0], ld_sh[63:32]};

    // Replicate store data across the word, rotate it to the lane offset, build the 8-lane mask
    always_comb begin
        st_rep = st_wdata;
        case (st_size)
            SZ_B:    st_rep = {4{st_wdata[7:0]}};
            SZ_H:    st_rep = {2{st_wdata[15:0]}};
            default: st_rep = st_wdata;
        endcase
        st_rot  = {st_rep, st_rep} << {st_off, 3'b000};
        st_din  = st_rot[63:32];
        st_mask = {4'b0000, size_lanes(st_size)} << st_off;
    end

    // Shift the two-word window down to the offset and sign/zero-extend
    always_comb begin
        ld_sh = {ld_hi, ld_lo} >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_unsigned & ld_sh[7]}},  ld_sh[7:0]};
            SZ_H:    ld_data = {{16{~ld_unsigned & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_data = ld_sh[31:0];
        endcase
    end

endmodule

// File: rtl/dpram_lsu_bridge.sv
// Load/store to SRAM port bridge. Macro MISALIGN_SPLIT_EN enables splitting
// word-crossing accesses into two SRAM cycles; otherwise they return an error.
module dpram_lsu_bridge
    import dpram_lsu_pkg::*;
#(
    parameter  int RAM_DEPTH = 65536,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);
    logic [7:0]    st_mask;
    logic [31:0]   st_din;
    logic [31:0]   ld_data;
    logic [31:0]   ld_lo;
    logic [AW-1:0] req_word;
    logic          req_cross;
    logic          req_err;
    logic          accept;
    logic          unused_addr;

    // Stage 1 = SRAM port cycle, stage 2 = response cycle
    logic [1:0]    vld_pipe;
    logic          s1_we, s1_uns, s1_err;
    logic [1:0]    s1_off, s1_size;
    logic          s2_we, s2_uns, s2_err;
    logic [1:0]    s2_off, s2_size;
    logic          s1_hold;

`ifdef MISALIGN_SPLIT_EN
    state_t        state;
    logic          req_split;
    logic          s1_cross, s1_first;
    logic [3:0]    s1_mask_hi;
    logic          s2_cross;
    logic [31:0]   lo_data;
`endif

    assign unused_addr = ^req_addr[31:AW+2];
    assign req_word    = req_addr[AW+1:2];
    assign req_cross   = (req_size != SZ_X) && (st_mask[7:4] != 4'b0000);

`ifdef MISALIGN_SPLIT_EN
    assign req_err   = (req_size == SZ_X);
    assign req_split = req_cross && !req_err;
    assign req_ready = !rst && (state == IDLE);
    assign s1_hold   = s1_cross && s1_first;
    assign ld_lo     = s2_cross ? lo_data : ram_dout;
`else
    assign req_err   = (req_size == SZ_X) || req_cross;
    assign req_ready = !rst;
    assign s1_hold   = 1'b0;
    assign ld_lo     = ram_dout;
`endif

    assign accept    = req_valid && req_ready;
    assign rsp_valid = vld_pipe[1];
    assign rsp_err   = vld_pipe[1] && s2_err;
    assign rsp_rdata = (vld_pipe[1] && !s2_we && !s2_err) ? ld_data : 32'h0;

    lsu_lane_align u_align (
        .st_off      (req_addr[1:0]),
        .st_size     (req_size),
        .st_wdata    (req_wdata),
        .st_mask     (st_mask),
        .st_din      (st_din),
        .ld_off      (s2_off),
        .ld_size     (s2_size),
        .ld_unsigned (s2_uns),
        .ld_lo       (ld_lo),
        .ld_hi       (ram_dout),
        .ld_data     (ld_data)
    );

    // SRAM port registers: single/phase-1 on accept, phase-2 from SPLIT
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_wem  <= 4'b0000;
            ram_addr <= '0;
            ram_din  <= 32'h0;
`ifdef MISALIGN_SPLIT_EN
        end else if (state == SPLIT) begin
            ram_en   <= 1'b1;
            ram_addr <= ram_addr + AW'(1);
            ram_wem  <= s1_we ? s1_mask_hi : 4'b0000;
`endif
        end else if (accept && !req_err) begin
            ram_en   <= 1'b1;
            ram_we   <= req_we;
            ram_wem  <= req_we ? st_mask[3:0] : 4'b0000;
            ram_addr <= req_word;
            ram_din  <= st_din;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_wem  <= 4'b0000;
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // FSM: SPLIT lasts exactly one cycle after an accepted crossing request
    always_ff @(posedge clk) begin
        if (rst)                       state <= IDLE;
        else if (state == SPLIT)       state <= IDLE;
        else if (accept && req_split)  state <= SPLIT;
    end

    // Split bookkeeping and phase-1 read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cross   <= 1'b0;
            s1_first   <= 1'b0;
            s1_mask_hi <= 4'b0000;
            s2_cross   <= 1'b0;
            lo_data    <= 32'h0;
        end else begin
            if (state == SPLIT) begin
                s1_first <= 1'b0;
            end else if (accept) begin
                s1_cross   <= req_split;
                s1_first   <= 1'b1;
                s1_mask_hi <= st_mask[7:4];
            end
            if (vld_pipe[0] && !s1_hold)
                s2_cross <= s1_cross;
            if (vld_pipe[0] && s1_cross && !s1_first)
                lo_data <= ram_dout;
        end
    end
`endif

    // Request metadata pipeline; stage 1 holds through phase 2 of a split
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= 2'b00;
            s1_we    <= 1'b0;
            s1_uns   <= 1'b0;
            s1_err   <= 1'b0;
            s1_off   <= 2'b00;
            s1_size  <= 2'b00;
            s2_we    <= 1'b0;
            s2_uns   <= 1'b0;
            s2_err   <= 1'b0;
            s2_off   <= 2'b00;
            s2_size  <= 2'b00;
        end else begin
            if (req_ready) begin
                vld_pipe[0] <= accept;
                if (accept) begin
                    s1_we   <= req_we;
                    s1_uns  <= req_unsigned;
                    s1_err  <= req_err;
                    s1_off  <= req_addr[1:0];
                    s1_size <= req_size;
                end
            end
            vld_pipe[1] <= vld_pipe[0] && !s1_hold;
            if (vld_pipe[0] && !s1_hold) begin
                s2_we   <= s1_we;
                s2_uns  <= s1_uns;
                s2_err  <= s1_err;
                s2_off  <= s1_off;
                s2_size <= s1_size;
            end
        end
    end

endmodule

// File: tb/tb_dpram_lsu_bridge.sv
// Directed self-checking bench for dpram_lsu_bridge with a 1-cycle-latency SRAM model.
module tb_dpram_lsu_bridge;
    localparam int RAM_DEPTH = 65536;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:RAM_DEPTH-1];

    always #5 clk = ~clk;

    dpram_lsu_bridge #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // SRAM model: byte-masked write, registered read
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we && ram_wem[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle request; returns just after the accepting edge (start of T+1)
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = size; req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Single-cycle access: check port at T+1 and response at T+2
    task automatic single(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [3:0] exp_wem, input logic [31:0] exp_rdata);
        send(we, addr, size, uns, wdata);
        @(negedge clk);
        check({tag, "_en"},   {31'b0, ram_en}, 32'd1);
        check({tag, "_wem"},  {28'b0, ram_wem}, {28'b0, exp_wem});
        check({tag, "_addr"}, {16'b0, ram_addr}, {16'b0, addr[17:2]});
        check({tag, "_rv1"},  {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_rv"},   {31'b0, rsp_valid}, 32'd1);
        check({tag, "_err"},  {31'b0, rsp_err}, 32'd0);
        check({tag, "_data"}, rsp_rdata, exp_rdata);
    endtask

    // Access expected to be rejected with an error and no SRAM activity
    task automatic errored(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size);
        send(we, addr, size, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check({tag, "_en1"}, {31'b0, ram_en}, 32'd0);
        @(negedge clk);
        check({tag, "_en2"},  {31'b0, ram_en}, 32'd0);
        check({tag, "_rv"},   {31'b0, rsp_valid}, 32'd1);
        check({tag, "_err"},  {31'b0, rsp_err}, 32'd1);
        check({tag, "_data"}, rsp_rdata, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rv",    {31'b0, rsp_valid}, 32'd0);
        check("rst_en",    {31'b0, ram_en}, 32'd0);
        check("rst_wem",   {28'b0, ram_wem}, 32'd0);
        check("rst_addr",  {16'b0, ram_addr}, 32'd0);
        check("rst_din",   ram_din, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Word store / load
        single("st_w", 1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, 4'hF, 32'h0);
        single("ld_w", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 4'h0, 32'h11223344);

        // Byte/half loads with extension
        single("st_w2", 1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF0000, 4'hF, 32'h0);
        single("ld_bs", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 4'h0, 32'hFFFFFF80);
        single("ld_bu", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 4'h0, 32'h00000080);
        single("ld_hs", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 4'h0, 32'hFFFF80FF);

        // Misaligned-in-word half store: lanes 1..2, rotated data
        send(1'b1, 32'h11, 2'b01, 1'b0, 32'h0000BEEF);
        @(negedge clk);
        check("st_h_wem", {28'b0, ram_wem}, 32'h6);
        check("st_h_din", ram_din, 32'hEFBEEFBE);
        @(negedge clk);
        check("st_h_rv", {31'b0, rsp_valid}, 32'd1);
        single("ld_after_h", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 4'h0, 32'h80BEEF00);

        // Back-to-back loads, responses in order on consecutive cycles
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_addr = 32'h11; req_size = 2'b00; req_unsigned = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rv0", {31'b0, rsp_valid}, 32'd1);
        check("b2b_d0",  rsp_rdata, 32'h80BEEF00);
        @(negedge clk);
        check("b2b_rv1", {31'b0, rsp_valid}, 32'd1);
        check("b2b_d1",  rsp_rdata, 32'h000000EF);
        @(negedge clk);
        check("b2b_idle", {31'b0, rsp_valid}, 32'd0);

        // Illegal size
        errored("illegal", 1'b0, 32'h10, 2'b11);

`ifdef MISALIGN_SPLIT_EN
        // Split store across words 3/4
        send(1'b1, 32'h0E, 2'b10, 1'b0, 32'hAABBCCDD);
        @(negedge clk);
        check("sp_p1_en",   {31'b0, ram_en}, 32'd1);
        check("sp_p1_addr", {16'b0, ram_addr}, 32'd3);
        check("sp_p1_wem",  {28'b0, ram_wem}, 32'hC);
        check("sp_p1_din",  ram_din, 32'hCCDDAABB);
        check("sp_ready",   {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("sp_p2_addr", {16'b0, ram_addr}, 32'd4);
        check("sp_p2_wem",  {28'b0, ram_wem}, 32'h3);
        check("sp_ready2",  {31'b0, req_ready}, 32'd1);
        check("sp_rv_t2",   {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("sp_rv_t3",   {31'b0, rsp_valid}, 32'd1);

        // Split load back
        send(1'b0, 32'h0E, 2'b10, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("spl_rv_t2", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("spl_rv", {31'b0, rsp_valid}, 32'd1);
        check("spl_data", rsp_rdata, 32'hAABBCCDD);

        // Wrap from last word to word 0
        send(1'b1, 32'h0003FFFE, 2'b10, 1'b0, 32'h12345678);
        @(negedge clk);
        check("wrap_p1_addr", {16'b0, ram_addr}, 32'h0000FFFF);
        @(negedge clk);
        check("wrap_p2_addr", {16'b0, ram_addr}, 32'h0);
        check("wrap_p2_wem",  {28'b0, ram_wem}, 32'h3);
        @(negedge clk);
        send(1'b0, 32'h0003FFFE, 2'b10, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("wrap_ld", rsp_rdata, 32'h12345678);

        // Reset during phase 1 of a split store drops phase 2 and the response
        send(1'b1, 32'h2E, 2'b10, 1'b0, 32'h55667788);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_p1_en",   {31'b0, ram_en}, 32'd1);
        check("mrst_p1_addr", {16'b0, ram_addr}, 32'hB);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_no_p2", {31'b0, ram_en}, 32'd0);
        check("mrst_rv2",   {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("mrst_rv3",   {31'b0, rsp_valid}, 32'd0);
`else
        // Crossing accesses are rejected when splitting is disabled
        errored("cross_st", 1'b1, 32'h0E, 2'b10);
        errored("cross_wrap", 1'b0, 32'h0003FFFE, 2'b10);
        errored("cross_h", 1'b0, 32'h13, 2'b01);
        @(negedge clk);
        check("nosplit_ready", {31'b0, req_ready}, 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
